// File: rtl/mem_pkg.sv
// mem_pkg: shared size codes, FSM states and data width for the data-memory controller.
package mem_pkg;
    localparam int DATA_W = 32;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
endpackage

// File: rtl/controlador_memoria_datos_alineador.sv
// alineador_bytes: lane extraction with sign/zero extension for loads, lane merge for sub-word stores.
module alineador_bytes
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        lane,
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] load_value,
    output logic [DATA_W-1:0] merged
);
    logic [4:0]        sh;
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] bmask;
    // size[1] set means word (10 and 11); halves only look at lane[1]
    always_comb begin
        sh         = {lane, 3'b000};
        b          = 8'(word >> sh);
        h          = lane[1] ? word[31:16] : word[15:0];
        bmask      = 32'h0000_00FF << sh;
        load_value = size[1] ? word
                   : size[0] ? {{16{sgn & h[15]}}, h}
                   : {{24{sgn & b[7]}}, b};
        merged     = size[1] ? store_data
                   : size[0] ? (lane[1] ? {store_data[15:0], word[15:0]} : {word[31:16], store_data[15:0]})
                   : (word & ~bmask) | (DATA_W'(store_data[7:0]) << sh);
    end
endmodule

// File: rtl/controlador_memoria_datos.sv
// controlador_memoria_datos: MEM-stage load/store initiator with read-modify-write for sub-word stores.
// Optional MEM_MISALIGN_TRAP_EN rejects misaligned half/word accesses and adds the misaligned output.
module controlador_memoria_datos #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] load_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misaligned
`endif
);
    import mem_pkg::*;

    state_t            state, state_n;
    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        size_q;
    logic              sgn_q, store_q;
    logic [DATA_W-1:0] wdata_q, load_value, merged;
    logic              accept, bad, word_store;

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_q;
    assign bad        = (req_size == SZ_HALF && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
    assign misaligned = (state == RESP) & mis_q;
`else
    assign bad = 1'b0;
`endif

    assign accept     = (state == IDLE) & req_valid;
    assign word_store = req_store & req_size[1];
    assign req_ready  = state == IDLE;
    assign busy       = state != IDLE;
    assign done       = state == RESP;
    assign mem_read   = state == RD;
    assign mem_write  = state == WR;
    assign mem_addr   = addr_q[ADDR_W+1:2];

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !req_valid ? IDLE : bad ? RESP : word_store ? WR : RD;
            RD:      state_n = store_q ? WR : RESP;
            WR:      state_n = RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            size_q    <= SZ_BYTE;
            sgn_q     <= 1'b0;
            store_q   <= 1'b0;
            wdata_q   <= '0;
            mem_wdata <= '0;
            load_data <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                sgn_q   <= req_signed;
                store_q <= req_store;
                wdata_q <= req_wdata;
                if (word_store && !bad) mem_wdata <= req_wdata;
`ifdef MEM_MISALIGN_TRAP_EN
                mis_q   <= bad;
`endif
            end
            // the word read in RD feeds either the load result or the RMW merge
            if (state == RD) begin
                if (store_q) mem_wdata <= merged;
                else         load_data <= load_value;
            end
        end
    end

    alineador_bytes u_alineador (
        .word       (mem_rdata),
        .lane       (addr_q[1:0]),
        .size       (size_q),
        .sgn        (sgn_q),
        .store_data (wdata_q),
        .load_value (load_value),
        .merged     (merged)
    );
endmodule

// File: doc/controlador_memoria_datos.md
Name: controlador_memoria_datos

Overview:
- MEM-stage initiator for the word-organised data memory (`MemoriaDeDatos`).
- Takes one load/store request from the pipeline with a byte address, size and signedness.
- Drives the memory's `read`/`write`/`direccion`/`din` and returns aligned, extended load data.
- Sub-word stores run as a read-modify-write sequence, so the block stalls the pipeline while busy.

Parameters:
- ADDR_W, 10, word-address width driven to the memory (`direccion`); byte address is ADDR_W+2 bits.
- DATA_W, 32, memory word width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock; state and captures on posedge; the memory samples on negedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on a posedge where req_valid&req_ready.
- req_store  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_signed  in  1  loads only: sign-extend (1) or zero-extend (0).
- req_addr  in  ADDR_W+2  byte address, little-endian lanes.
- req_wdata  in  32  store data; the low byte/half is used for sub-word stores.
- busy  out  1  state != IDLE; drives the pipeline stall.
- done  out  1  one-cycle pulse in RESP.
- load_data  out  32  extended load result; valid while done=1, held until next accept.
- mem_read  out  1  to memory `read`.
- mem_write  out  1  to memory `write`.
- mem_addr  out  ADDR_W  to memory `direccion` (req_addr[ADDR_W+1:2], latched).
- mem_wdata  out  32  to memory `din`.
- mem_rdata  in  32  from memory `dout`.

Behaviour:
- States: IDLE, RD, WR, RESP.
- mem_read, mem_write and mem_addr are decoded only from registered state/latches, never from req_* directly. They are therefore stable before the memory's negedge.
- Reset (async): state=IDLE; req_ready=1; busy=0; done=0; mem_read=0; mem_write=0; mem_addr=0; mem_wdata=0; load_data=0.
- Accept: latch addr, size, signed, store and wdata.
  - Load goes to RD.
  - Word store goes to WR, with mem_wdata=req_wdata.
  - Byte/half store goes to RD.
- RD:
  - mem_read=1.
  - At the next posedge, capture mem_rdata.
  - Load: extract the lane, extend it into load_data, then go to RESP.
  - Sub-word store: merge the store lane into the captured word to form mem_wdata, then go to WR.
- WR: mem_write=1 for exactly one cycle, then RESP.
- RESP: done=1 for exactly one cycle, then IDLE. No request is accepted in RESP.
- Latency (accept edge to done cycle): load 2 cycles, word store 2, sub-word store 3.
- Lane rules:
  - Byte lane = addr[1:0].
  - Half lane = addr[1] (half at bits [15:0] or [31:16]).
  - Zero-extension fills the upper bits with 0.
  - Sign-extension replicates bit 7 (byte) or bit 15 (half).
  - Merge keeps every non-target byte of the read word unchanged.
- Simultaneous events: req_valid while busy is ignored; the requester must hold it until req_ready.
- Reset during RD/WR: outputs drop immediately and the pending write is lost. No partial RMW result is ever written.
- The address wraps modulo 2^ADDR_W words; there is no range error.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, is rejected.
  - No memory cycle is issued; the block goes directly to RESP.
  - An extra output `misaligned` (1 bit) pulses with done; load_data is unchanged.
  - `misaligned` resets to 0.
- Undefined:
  - No `misaligned` port.
  - Low address bits are forced aligned: half uses addr[1] only, word ignores addr[1:0].

Decomposition:
- Package `mem_pkg`:
  - size codes: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - state enum: IDLE, RD, WR, RESP.
  - DATA_W constant.
- One sub-module, `alineador_bytes`, combinational.
  - Inputs: word, lane, size, signed, store data.
  - Outputs: extended load value and merged store word.
  - Instantiated once.

Test Plan:
- Memory holds 0x000001FF at word 29 and 0x00000003 at word 30:
  - Load word, addr 120 -> done 2 cycles after accept, load_data=0x00000003, mem_read high exactly 1 cycle.
  - Store byte 0xAB, addr 117 (word 29 holds 0x000001FF) -> RD, WR, RESP; mem_wdata=0x0000ABFF during the mem_write cycle; then a signed byte load from 117 returns 0xFFFFFFAB and an unsigned one returns 0x000000AB.
  - Store half 0x8001, addr 122 -> word 30 becomes 0x80010003; signed half load from 122 returns 0xFFFF8001.
- Back-to-back and busy behaviour:
  - Second request held during busy -> accepted only on the first edge after RESP; req_ready low for 2 or 3 cycles as per latency.
- Reset mid-operation:
  - Sub-word store, reset asserted during RD -> mem_write never asserts, memory word unchanged, all outputs at reset values.
- Misalignment:
  - MEM_MISALIGN_TRAP_EN defined: word load at addr 121 -> misaligned=1 with done, mem_read never high.
  - Undefined: the same request reads word 30.
